trig_cond: RTL and testbench

- Conditions the raw analog comparator output before it reaches the period counter.
- Synchronises the asynchronous comparator output into the clk domain and rejects glitches shorter than FILT_LEN cycles with a qualify state machine.
- Produces a clean trigger level plus one-cycle edge strobes.
- Reports rejected glitches and a watchdog timeout when no qualified edge occurs.

---
 rtl/trig_cond.sv | 167 ++++++++++++++++
 tb/tb_trig_cond.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/trig_cond.sv
// Comparator trigger conditioner: synchronises cmp_in, qualifies level changes
// over FILT_LEN samples, emits edge strobes, glitch count and an edge watchdog.
module trig_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int TO_CYCLES   = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       cmp_in,
  output logic       trigger,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] glitch_cnt,
  output logic       timeout
);

  localparam int QW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TO_CYCLES + 1);
  localparam logic [QW-1:0] QLAST   = QW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_TERM = TW'(TO_CYCLES);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE_QUAL,
    ST_HIGH,
    ST_FALL_QUAL
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [QW-1:0]          qcnt_q, qcnt_d;
  logic                   trig_q, trig_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_inc;
  logic [7:0]             glitch_q, glitch_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   to_q, to_d;
  logic                   edge_d;

  // Oldest flop of the chain is the only view of the comparator downstream.
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_LOW;
      qcnt_q   <= '0;
      trig_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      trig_q   <= trig_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
    end
  end

  // qcnt counts consecutive samples at the new level; the first one is taken
  // on the transition out of LOW/HIGH.
  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    trig_d     = trig_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          if (FILT_LEN == 1) begin
            state_d = ST_HIGH;
            trig_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = ST_RISE_QUAL;
            qcnt_d  = QW'(1);
          end
        end
      end
      ST_RISE_QUAL: begin
        if (s) begin
          if (qcnt_q == QLAST) begin
            state_d = ST_HIGH;
            qcnt_d  = '0;
            trig_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            qcnt_d = qcnt_q + QW'(1);
          end
        end else begin
          state_d    = ST_LOW;
          qcnt_d     = '0;
          glitch_inc = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          if (FILT_LEN == 1) begin
            state_d = ST_LOW;
            trig_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = ST_FALL_QUAL;
            qcnt_d  = QW'(1);
          end
        end
      end
      ST_FALL_QUAL: begin
        if (!s) begin
          if (qcnt_q == QLAST) begin
            state_d = ST_LOW;
            qcnt_d  = '0;
            trig_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            qcnt_d = qcnt_q + QW'(1);
          end
        end else begin
          state_d    = ST_HIGH;
          qcnt_d     = '0;
          glitch_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        qcnt_d  = '0;
        trig_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_inc && (glitch_q != 8'hFF)) glitch_d = glitch_q + 8'd1;
  end

  // A qualified edge beats the terminal count landing in the same cycle.
  always_comb begin
    edge_d = rise_d | fall_d;
    if (edge_d)                     to_cnt_d = '0;
    else if (to_cnt_q == TO_TERM)   to_cnt_d = to_cnt_q;
    else                            to_cnt_d = to_cnt_q + TW'(1);
    to_d = !edge_d && (to_cnt_d == TO_TERM);
  end

  assign trigger    = trig_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign glitch_cnt = glitch_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_trig_cond.sv
// Directed bench for trig_cond: default instance plus a TO_CYCLES=10 instance.
module tb_trig_cond;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       cmp_in;
  logic       trigger, rise_pulse, fall_pulse, timeout;
  logic [7:0] glitch_cnt;
  logic       trigger10, rise10, fall10, timeout10;
  logic [7:0] glitch10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trig_cond dut (
    .clk(clk), .n_rst(n_rst), .cmp_in(cmp_in),
    .trigger(trigger), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .glitch_cnt(glitch_cnt), .timeout(timeout)
  );

  trig_cond #(.TO_CYCLES(10)) dut10 (
    .clk(clk), .n_rst(n_rst), .cmp_in(cmp_in),
    .trigger(trigger10), .rise_pulse(rise10), .fall_pulse(fall10),
    .glitch_cnt(glitch10), .timeout(timeout10)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_rst  = 1'b0;
    cmp_in = 1'b1;
    tick(2);
    chk("rst_trigger", trigger, 0);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_fall", fall_pulse, 0);
    chk("rst_glitch", glitch_cnt, 0);
    chk("rst_timeout", timeout, 0);

    // Release with cmp_in already high: rise after edge k+5.
    n_rst = 1'b1;
    tick(5);
    chk("lat_trig_k4", trigger, 0);
    chk("lat_rise_k4", rise_pulse, 0);
    tick(1);
    chk("lat_trig_k5", trigger, 1);
    chk("lat_rise_k5", rise_pulse, 1);
    chk("lat_rise10_k5", rise10, 1);
    tick(1);
    chk("lat_rise_k6", rise_pulse, 0);
    chk("lat_trig_k6", trigger, 1);
    chk("lat_glitch", glitch_cnt, 0);

    // Watchdog: timeout on the 255th cycle after the rise pulse.
    tick(253);
    chk("to_254", timeout, 0);
    tick(1);
    chk("to_255", timeout, 1);
    chk("to10_held", timeout10, 1);
    cmp_in = 1'b0;
    tick(5);
    chk("fall_k4", fall_pulse, 0);
    chk("fall_k4_to", timeout, 1);
    chk("fall_k4_trig", trigger, 1);
    tick(1);
    chk("fall_k5", fall_pulse, 1);
    chk("fall_k5_to", timeout, 0);
    chk("fall_k5_trig", trigger, 0);
    chk("fall10_k5", fall10, 1);
    chk("fall10_k5_to", timeout10, 0);

    // TO_CYCLES=10: next rise lands exactly on the terminal cycle.
    tick(4);
    cmp_in = 1'b1;
    tick(5);
    chk("term_to10_pre", timeout10, 0);
    chk("term_rise10_pre", rise10, 0);
    tick(1);
    chk("term_rise10", rise10, 1);
    chk("term_to10", timeout10, 0);
    tick(9);
    chk("term_to10_9", timeout10, 0);
    tick(1);
    chk("term_to10_10", timeout10, 1);

    // Back to low, then a 3-cycle high glitch is rejected.
    cmp_in = 1'b0;
    tick(10);
    chk("low_trig", trigger, 0);
    chk("low_glitch", glitch_cnt, 0);
    cmp_in = 1'b1;
    tick(3);
    cmp_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("g3_rise", rise_pulse, 0);
      chk("g3_trig", trigger, 0);
    end
    chk("g3_glitch", glitch_cnt, 1);

    // 4-cycle pulse qualifies, then falls.
    cmp_in = 1'b1;
    tick(4);
    cmp_in = 1'b0;
    tick(2);
    chk("p4_rise", rise_pulse, 1);
    chk("p4_trig", trigger, 1);
    tick(4);
    chk("p4_fall", fall_pulse, 1);
    chk("p4_trig_low", trigger, 0);
    chk("p4_glitch", glitch_cnt, 1);

    // 300 single-cycle glitches saturate the counter.
    for (int i = 0; i < 10; i++) begin
      cmp_in = 1'b1; tick(1);
      cmp_in = 1'b0; tick(1);
    end
    tick(4);
    chk("sat_11", glitch_cnt, 11);
    for (int i = 0; i < 290; i++) begin
      cmp_in = 1'b1; tick(1);
      cmp_in = 1'b0; tick(1);
    end
    tick(4);
    chk("sat_255", glitch_cnt, 255);
    chk("sat_trig", trigger, 0);
    cmp_in = 1'b1; tick(1);
    cmp_in = 1'b0; tick(5);
    chk("sat_hold", glitch_cnt, 255);
    chk("pre_rst_to", timeout, 1);

    // Reset mid RISE_QUAL (qcnt=2) aborts immediately.
    cmp_in = 1'b1;
    tick(4);
    chk("mid_trig_pre", trigger, 0);
    n_rst = 1'b0;
    #1;
    chk("mid_trig", trigger, 0);
    chk("mid_rise", rise_pulse, 0);
    chk("mid_fall", fall_pulse, 0);
    chk("mid_glitch", glitch_cnt, 0);
    chk("mid_to", timeout, 0);
    tick(2);
    n_rst = 1'b1;
    tick(5);
    chk("req_rise_pre", rise_pulse, 0);
    tick(1);
    chk("req_rise", rise_pulse, 1);
    chk("req_trig", trigger, 1);
    chk("req_glitch", glitch_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
